// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: a cache request FSM (RUN/DRAIN) feeding a small PC/instruction FIFO.
// Optional performance counters are enabled by defining FETCH_BUFFER_PERF_EN.
module fetch_buffer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_i,
  output logic        cache_read_o,
  output logic [31:0] cache_addr_o,
  input  logic [31:0] cache_data_i,
  input  logic        cache_valid_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
`ifdef FETCH_BUFFER_PERF_EN
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_stall_cnt_o,
`endif
  input  logic        ready_i
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   pending_pc;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   instr_mem [FIFO_DEPTH];
  logic [31:0]   pc_mem    [FIFO_DEPTH];

  logic [31:0]   target;
  logic          push;
  logic          pop;
  logic          unused_addr_bits;

  assign target           = {branch_addr_i[31:2], 2'b00};
  assign unused_addr_bits = ^branch_addr_i[1:0];

  // Request depends only on registered state, so the cache sees no combinational loop.
  assign cache_read_o = (state == DRAIN) || (count != CW'(FIFO_DEPTH));
  assign cache_addr_o = fetch_pc;

  assign push = (state == RUN) && cache_read_o && cache_valid_i && !branch_i;
  assign pop  = valid_o && ready_i && !branch_i;

  assign valid_o = (count != '0);
  assign instr_o = instr_mem[rd_ptr];
  assign pc_o    = pc_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= cache_data_i;
      pc_mem[wr_ptr]    <= fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state      <= RUN;
      fetch_pc   <= RESET_PC;
      pending_pc <= '0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      if (branch_i) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        count <= count + CW'(push) - CW'(pop);
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end

      case (state)
        RUN: begin
          if (branch_i) begin
            // An unanswered miss must complete at its original address before redirecting.
            if (cache_read_o && !cache_valid_i) begin
              state      <= DRAIN;
              pending_pc <= target;
            end else begin
              fetch_pc <= target;
            end
          end else if (push) begin
            fetch_pc <= fetch_pc + 32'd4;
          end
        end
        DRAIN: begin
          if (branch_i) begin
            pending_pc <= target;
            if (cache_valid_i) begin
              fetch_pc <= target;
              state    <= RUN;
            end
          end else if (cache_valid_i) begin
            fetch_pc <= pending_pc;
            state    <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef FETCH_BUFFER_PERF_EN
  always_ff @(posedge clk) begin
    if (rst_i) begin
      perf_fetch_cnt_o <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (push)                          perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
      if (cache_read_o && !cache_valid_i) perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed testbench for fetch_buffer with a simple hit/manual cache model.
module tb_fetch_buffer;

  logic        clk;
  logic        rst_i;
  logic        cache_read_o;
  logic [31:0] cache_addr_o;
  logic [31:0] cache_data_i;
  logic        cache_valid_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        ready_i;
`ifdef FETCH_BUFFER_PERF_EN
  logic [31:0] perf_fetch_cnt_o;
  logic [31:0] perf_stall_cnt_o;
`endif

  logic        hit_en;
  logic        man_valid;
  logic [31:0] man_data;

  int n_checks;
  int n_errors;

  // Hit mode answers every request immediately with data equal to the address.
  assign cache_valid_i = hit_en ? cache_read_o : man_valid;
  assign cache_data_i  = hit_en ? cache_addr_o : man_data;

  fetch_buffer #(.FIFO_DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_i         (rst_i),
    .cache_read_o  (cache_read_o),
    .cache_addr_o  (cache_addr_o),
    .cache_data_i  (cache_data_i),
    .cache_valid_i (cache_valid_i),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .valid_o       (valid_o),
`ifdef FETCH_BUFFER_PERF_EN
    .perf_fetch_cnt_o (perf_fetch_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o),
`endif
    .ready_i       (ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic hit, input logic rdy);
    rst_i     = 1'b1;
    hit_en    = hit;
    ready_i   = rdy;
    man_valid = 1'b0;
    branch_i  = 1'b0;
    step();
    step();
    rst_i = 1'b0;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    branch_addr_i = '0;
    man_data      = '0;

    // Reset state and streaming with an always-hit cache
    do_reset(1'b1, 1'b1);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_read", 32'(cache_read_o), 32'd1);
    check("rst_addr", cache_addr_o, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("stream_pc", pc_o, 32'(4 * i));
      check("stream_instr", instr_o, 32'(4 * i));
      check("stream_read", 32'(cache_read_o), 32'd1);
    end

    // Fill to capacity with no consumer, then single pop
    do_reset(1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("fill_read", 32'(cache_read_o), (k < 4) ? 32'd1 : 32'd0);
      check("fill_head", pc_o, 32'h0);
    end
    check("full_addr", cache_addr_o, 32'h10);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    check("pop_read", 32'(cache_read_o), 32'd1);
    check("pop_addr", cache_addr_o, 32'h10);
    check("pop_head", pc_o, 32'h4);
    step();
    check("refull_read", 32'(cache_read_o), 32'd0);
    // Branch with nothing outstanding (FIFO full)
    branch_i      = 1'b1;
    branch_addr_i = 32'h300;
    step();
    branch_i = 1'b0;
    check("br_idle_valid", 32'(valid_o), 32'd0);
    check("br_idle_addr", cache_addr_o, 32'h300);
    check("br_idle_read", 32'(cache_read_o), 32'd1);

    // Long miss at 0x40 with a redirect to 0x103 during the miss
    do_reset(1'b0, 1'b1);
    branch_i      = 1'b1;
    branch_addr_i = 32'h40;
    man_valid     = 1'b1;
    man_data      = 32'hBAD0_BAD0;
    step();
    branch_i  = 1'b0;
    man_valid = 1'b0;
    check("miss_addr0", cache_addr_o, 32'h40);
    check("miss_valid0", 32'(valid_o), 32'd0);
    for (int c = 1; c <= 10; c++) begin
      branch_i      = (c == 3);
      branch_addr_i = 32'h103;
      man_valid     = (c == 10);
      man_data      = 32'hDEAD_BEEF;
      step();
      branch_i = 1'b0;
      if (c < 10) begin
        check("miss_hold_addr", cache_addr_o, 32'h40);
        check("miss_read", 32'(cache_read_o), 32'd1);
      end
    end
    man_valid = 1'b0;
    check("drain_addr", cache_addr_o, 32'h100);
    check("drain_discard", 32'(valid_o), 32'd0);
    man_valid = 1'b1;
    man_data  = 32'h1234_5678;
    step();
    man_valid = 1'b0;
    check("tgt_valid", 32'(valid_o), 32'd1);
    check("tgt_pc", pc_o, 32'h100);
    check("tgt_instr", instr_o, 32'h1234_5678);

    // Branch coincident with a hit and a pop while holding 3 entries
    do_reset(1'b1, 1'b0);
    step();
    step();
    step();
    check("three_head", pc_o, 32'h0);
    ready_i       = 1'b1;
    branch_i      = 1'b1;
    branch_addr_i = 32'h200;
    step();
    branch_i = 1'b0;
    check("flush_valid", 32'(valid_o), 32'd0);
    check("flush_addr", cache_addr_o, 32'h200);
    check("flush_read", 32'(cache_read_o), 32'd1);
    step();
    check("flush_tgt_pc", pc_o, 32'h200);
    check("flush_tgt_valid", 32'(valid_o), 32'd1);

    // Fetch PC wrap at the top of the address space, unaligned target masked
    branch_i      = 1'b1;
    branch_addr_i = 32'hFFFF_FFFF;
    step();
    branch_i = 1'b0;
    check("wrap_addr", cache_addr_o, 32'hFFFF_FFFC);
    check("wrap_valid", 32'(valid_o), 32'd0);
    step();
    check("wrap_pc", pc_o, 32'hFFFF_FFFC);
    check("wrap_next", cache_addr_o, 32'h0);
    step();
    check("wrap_pc0", pc_o, 32'h0);
    check("wrap_next4", cache_addr_o, 32'h4);

    // Reset in the middle of a drain abandons the pending redirect
    do_reset(1'b0, 1'b1);
    branch_i      = 1'b1;
    branch_addr_i = 32'h500;
    step();
    branch_i = 1'b0;
    check("drain_keep", cache_addr_o, 32'h0);
    rst_i = 1'b1;
    step();
    rst_i     = 1'b0;
    man_valid = 1'b1;
    man_data  = 32'hCAFE_0000;
    step();
    man_valid = 1'b0;
    check("rst_mid_pc", pc_o, 32'h0);
    check("rst_mid_valid", 32'(valid_o), 32'd1);

`ifdef FETCH_BUFFER_PERF_EN
    do_reset(1'b1, 1'b1);
    check("perf_rst_fetch", perf_fetch_cnt_o, 32'd0);
    for (int i = 0; i < 5; i++) step();
    check("perf_fetch", perf_fetch_cnt_o, 32'd5);
    check("perf_nostall", perf_stall_cnt_o, 32'd0);
    hit_en    = 1'b0;
    man_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("perf_stall", perf_stall_cnt_o, 32'd3);
    check("perf_fetch_hold", perf_fetch_cnt_o, 32'd5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
